// File: rtl/turn_scheduler_if.sv
// ============================================================================
// Module      : turn_scheduler_if
// Description : Strobe/status bundle between the card-selection FSM (master)
//               and the turn scheduler (slave). Directions in the signal
//               names (_i/_o) are as seen from the scheduler.
// Ports       : start_i, restart_timer_i, start_pause_i, end_turn_i,
//               extra_turn_i, match_found_i            (master -> slave)
//               time_up_o, pause_done_o, seconds_left_o[4:0],
//               current_player_o, score_p1_o[3:0], score_p2_o[3:0],
//               pairs_left_o[3:0], game_over_o, winner_o[1:0],
//               phase_o[1:0]                            (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface turn_scheduler_if;
    logic       start_i;
    logic       restart_timer_i;
    logic       start_pause_i;
    logic       end_turn_i;
    logic       extra_turn_i;
    logic       match_found_i;

    logic       time_up_o;
    logic       pause_done_o;
    logic [4:0] seconds_left_o;
    logic       current_player_o;
    logic [3:0] score_p1_o;
    logic [3:0] score_p2_o;
    logic [3:0] pairs_left_o;
    logic       game_over_o;
    logic [1:0] winner_o;
    logic [1:0] phase_o;

    modport master (
        output start_i, restart_timer_i, start_pause_i,
               end_turn_i, extra_turn_i, match_found_i,
        input  time_up_o, pause_done_o, seconds_left_o, current_player_o,
               score_p1_o, score_p2_o, pairs_left_o, game_over_o,
               winner_o, phase_o
    );

    modport slave (
        input  start_i, restart_timer_i, start_pause_i,
               end_turn_i, extra_turn_i, match_found_i,
        output time_up_o, pause_done_o, seconds_left_o, current_player_o,
               score_p1_o, score_p2_o, pairs_left_o, game_over_o,
               winner_o, phase_o
    );
endinterface

`default_nettype wire

// File: rtl/turn_scheduler.sv
// ============================================================================
// Module      : turn_scheduler
// Description : Turn countdown, mismatch pause and score keeping for the
//               two-player memory game. Consumes the card-selection FSM's
//               turn-outcome strobes and reports timing pulses, scores,
//               remaining pairs, phase and winner.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - turn_scheduler_if.slave (strobes in, status out)
// Config      : TURN_SCHED_SIM_FAST_EN defined -> 16-cycle second tick and
//               8-cycle pause, independent of CLK_HZ / PAUSE_MS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_scheduler #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 15,
    parameter int PAUSE_MS     = 1000,
    parameter int NUM_PAIRS    = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    turn_scheduler_if.slave bus
);

`ifdef TURN_SCHED_SIM_FAST_EN
    localparam int TICK_CYCLES  = 16;
    localparam int PAUSE_CYCLES = 8;
`else
    localparam int TICK_CYCLES  = CLK_HZ;
    localparam int PAUSE_CYCLES = (CLK_HZ / 1000) * PAUSE_MS;
`endif

    localparam int TICK_W  = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
    // The pause counter is loaded with PAUSE_CYCLES-1 and pulses once it reads 0.
    localparam int PAUSE_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [4:0]         TURN_LOAD  = 5'(TURN_SECONDS);
    localparam logic [3:0]         PAIRS_LOAD = 4'(NUM_PAIRS);

    typedef enum logic [1:0] {
        PH_WAIT  = 2'b00,
        PH_RUN   = 2'b01,
        PH_PAUSE = 2'b10,
        PH_OVER  = 2'b11
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [4:0]         sec_q, sec_d;
    logic [PAUSE_W-1:0] pcnt_q, pcnt_d;
    logic               time_up_q, time_up_d;
    logic               pause_done_q, pause_done_d;
    logic               player_q, player_d;
    logic [3:0]         score1_q, score1_d;
    logic [3:0]         score2_q, score2_d;
    logic [3:0]         pairs_q, pairs_d;
    logic [1:0]         winner_q, winner_d;

    logic               reload;
    logic               count_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_WAIT;
            presc_q      <= '0;
            sec_q        <= TURN_LOAD;
            pcnt_q       <= '0;
            time_up_q    <= 1'b0;
            pause_done_q <= 1'b0;
            player_q     <= 1'b0;
            score1_q     <= '0;
            score2_q     <= '0;
            pairs_q      <= PAIRS_LOAD;
            winner_q     <= 2'b00;
        end else begin
            phase_q      <= phase_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            pcnt_q       <= pcnt_d;
            time_up_q    <= time_up_d;
            pause_done_q <= pause_done_d;
            player_q     <= player_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            pairs_q      <= pairs_d;
            winner_q     <= winner_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        presc_d      = presc_q;
        sec_d        = sec_q;
        pcnt_d       = pcnt_q;
        time_up_d    = 1'b0;
        pause_done_d = 1'b0;
        player_d     = player_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        pairs_d      = pairs_q;
        winner_d     = winner_q;
        reload       = 1'b0;
        count_en     = 1'b0;

        if (bus.start_i) begin
            phase_d  = PH_RUN;
            presc_d  = '0;
            sec_d    = TURN_LOAD;
            pcnt_d   = '0;
            player_d = 1'b0;
            score1_d = '0;
            score2_d = '0;
            pairs_d  = PAIRS_LOAD;
            winner_d = 2'b00;
        end else begin
            unique case (phase_q)
                PH_RUN: begin
                    reload   = bus.restart_timer_i | bus.extra_turn_i | bus.end_turn_i;
                    // A pause request freezes the countdown in its own cycle,
                    // which also swallows an expiry landing there.
                    count_en = ~bus.start_pause_i;
                    if (bus.end_turn_i) begin
                        player_d = ~player_q;
                    end
                    if (bus.match_found_i) begin
                        if (player_q) begin
                            score2_d = (score2_q == 4'hF) ? score2_q : score2_q + 4'd1;
                        end else begin
                            score1_d = (score1_q == 4'hF) ? score1_q : score1_q + 4'd1;
                        end
                        if (pairs_q != 4'd0) begin
                            pairs_d = pairs_q - 4'd1;
                        end
                        if (pairs_q <= 4'd1) begin
                            // Last pair claimed: timers stop where they are.
                            phase_d  = PH_OVER;
                            reload   = 1'b0;
                            count_en = 1'b0;
                            if (score1_d > score2_d) begin
                                winner_d = 2'b01;
                            end else if (score2_d > score1_d) begin
                                winner_d = 2'b10;
                            end else begin
                                winner_d = 2'b11;
                            end
                        end
                    end
                    if (bus.start_pause_i && (phase_d == PH_RUN)) begin
                        phase_d = PH_PAUSE;
                        pcnt_d  = PAUSE_LOAD;
                    end
                end
                PH_PAUSE: begin
                    // The countdown resumes on the expiry cycle and the pulse
                    // cycle, so exactly PAUSE_CYCLES turn cycles are lost.
                    if (pause_done_q) begin
                        phase_d  = PH_RUN;
                        count_en = 1'b1;
                        if (bus.end_turn_i) begin
                            player_d = ~player_q;
                            reload   = 1'b1;
                        end
                    end else if (pcnt_q == '0) begin
                        pause_done_d = 1'b1;
                        count_en     = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q - PAUSE_W'(1);
                    end
                end
                default: begin
                    // WAIT and OVER hold everything until the next start.
                end
            endcase

            // A reload in the expiry cycle wins and suppresses time_up.
            if (reload) begin
                presc_d = '0;
                sec_d   = TURN_LOAD;
            end else if (count_en) begin
                if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    if (sec_q <= 5'd1) begin
                        sec_d     = TURN_LOAD;
                        time_up_d = 1'b1;
                    end else begin
                        sec_d = sec_q - 5'd1;
                    end
                end else begin
                    presc_d = presc_q + TICK_W'(1);
                end
            end
        end
    end

    assign bus.time_up_o        = time_up_q;
    assign bus.pause_done_o     = pause_done_q;
    assign bus.seconds_left_o   = sec_q;
    assign bus.current_player_o = player_q;
    assign bus.score_p1_o       = score1_q;
    assign bus.score_p2_o       = score2_q;
    assign bus.pairs_left_o     = pairs_q;
    assign bus.game_over_o      = (phase_q == PH_OVER);
    assign bus.winner_o         = winner_q;
    assign bus.phase_o          = phase_q;

endmodule

`default_nettype wire
